seg_serial_rx: RTL and testbench

- Receive-side counterpart of the board's serial seven-segment driver interface (SEGCLK/SEGCLR/SEGDT/SEGEN).
- Oversamples the four serial lines in the system clock domain and deserialises the segment bit stream into complete parallel frames.
- Flags aborted and stalled frames.
- Sits beside the display driver in simulation benches and on-chip self-check logic, so the transmitted digit pattern can be compared against its expected value.

---
 rtl/seg_serial_rx.sv | 118 +++++++++++
 tb/tb_seg_serial_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_serial_rx.sv
// Receive side of the serial seven-segment link. It synchronises SEGCLK/SEGCLR/SEGDT/SEGEN into clk
// and deserialises the bit stream into parallel frames, flagging aborted and stalled frames.
module seg_serial_rx #(
  parameter int FRAME_BITS  = 64,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            SEGCLK,
  input  logic                            SEGCLR,
  input  logic                            SEGDT,
  input  logic                            SEGEN,
  output logic [FRAME_BITS-1:0]           frame_data,
  output logic                            frame_valid,
  output logic                            frame_err,
  output logic [1:0]                      err_code,
  output logic [$clog2(FRAME_BITS+1)-1:0] bit_cnt,
  output logic                            busy,
  output logic                            seg_en
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dt_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic [SYNC_STAGES-1:0] en_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   dt_s;
  logic                   clr_s;
  logic                   seg_rise;
  logic [FRAME_BITS-1:0]  sreg;
  logic [TW-1:0]          tcnt;

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign dt_s     = dt_sync[SYNC_STAGES-1];
  assign clr_s    = clr_sync[SYNC_STAGES-1];
  assign seg_en   = en_sync[SYNC_STAGES-1];
  assign seg_rise = clk_s & ~clk_prev;
  assign busy     = (bit_cnt != '0);

  // The SEGCLR chain resets high, so that reset does not look like a clear request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= '0;
      dt_sync  <= '0;
      clr_sync <= '1;
      en_sync  <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], SEGCLK};
      dt_sync  <= {dt_sync[SYNC_STAGES-2:0], SEGDT};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], SEGCLR};
      en_sync  <= {en_sync[SYNC_STAGES-2:0], SEGEN};
      clk_prev <= clk_s;
    end
  end

  // Priority: clear beats a shift edge, and a shift edge beats the stall timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sreg        <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'b00;
      bit_cnt     <= '0;
      tcnt        <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (!clr_s) begin
        sreg    <= '0;
        bit_cnt <= '0;
        tcnt    <= '0;
        state   <= IDLE;
        if (bit_cnt != '0) begin
          frame_err <= 1'b1;
          err_code  <= 2'b01;
        end
      end else if (seg_rise) begin
        tcnt <= '0;
        if (bit_cnt == CW'(FRAME_BITS - 1)) begin
          frame_data  <= {sreg[FRAME_BITS-2:0], dt_s};
          frame_valid <= 1'b1;
          sreg        <= '0;
          bit_cnt     <= '0;
          state       <= IDLE;
        end else begin
          sreg    <= {sreg[FRAME_BITS-2:0], dt_s};
          bit_cnt <= bit_cnt + CW'(1);
          state   <= SHIFT;
        end
      end else if (state == SHIFT) begin
        if (tcnt == TW'(TIMEOUT - 1)) begin
          frame_err <= 1'b1;
          err_code  <= 2'b10;
          sreg      <= '0;
          bit_cnt   <= '0;
          tcnt      <= '0;
          state     <= IDLE;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg_serial_rx.sv
// Bench for seg_serial_rx: drives the serial link and compares captured frames and error codes
// against a bit-queue model of the link.
module tb_seg_serial_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        SEGCLK = 1'b0;
  logic        SEGCLR = 1'b1;
  logic        SEGDT = 1'b0;
  logic        SEGEN = 1'b0;
  logic [63:0] frame_data;
  logic        frame_valid;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [6:0]  bit_cnt;
  logic        busy;
  logic        seg_en;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int err_cyc = 0;
  int last_cnt_cyc = 0;
  int overlap = 0;
  int stable_viol = 0;
  logic [63:0] prev_fd = '0;
  logic [6:0]  prev_cnt = '0;

  logic        rx_bits[$];
  logic [63:0] exp_frames[$];
  logic [1:0]  exp_errs[$];
  logic [63:0] got_frames[$];
  logic [1:0]  got_errs[$];

  seg_serial_rx #(.FRAME_BITS(64), .SYNC_STAGES(2), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .SEGCLK(SEGCLK), .SEGCLR(SEGCLR), .SEGDT(SEGDT), .SEGEN(SEGEN),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err),
    .err_code(err_code), .bit_cnt(bit_cnt), .busy(busy), .seg_en(seg_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observe outputs half a cycle after the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      prev_fd  = '0;
      prev_cnt = '0;
    end else begin
      if (frame_valid) got_frames.push_back(frame_data);
      if (frame_err) begin
        got_errs.push_back(err_code);
        err_cyc = cyc;
      end
      if (frame_valid && frame_err) overlap++;
      if (frame_data != prev_fd && !frame_valid) stable_viol++;
      if (bit_cnt != prev_cnt && bit_cnt != 0) last_cnt_cyc = cyc;
      prev_fd  = frame_data;
      prev_cnt = bit_cnt;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a frame is simply the 64 most recent accepted bits, first bit in the MSB.
  task automatic modelBit(input logic b);
    logic [63:0] v;
    rx_bits.push_back(b);
    if (rx_bits.size() == 64) begin
      v = '0;
      foreach (rx_bits[i]) v = {v[62:0], rx_bits[i]};
      exp_frames.push_back(v);
      rx_bits.delete();
    end
  endtask

  task automatic modelClear();
    if (rx_bits.size() != 0) exp_errs.push_back(2'b01);
    rx_bits.delete();
  endtask

  task automatic sendBit(input logic b, input int hi, input int lo);
    SEGDT = b;
    repeat (lo) @(negedge clk);
    SEGCLK = 1'b1;
    repeat (hi) @(negedge clk);
    SEGCLK = 1'b0;
    modelBit(b);
  endtask

  task automatic applyStimulus(input logic [63:0] value, input int nbits, input bit rnd);
    logic [63:0] v;
    v = value;
    for (int i = 0; i < nbits; i++) begin
      if (rnd) sendBit(v[63], $urandom_range(3, 6), $urandom_range(3, 6));
      else     sendBit(v[63], 4, 4);
      v = v << 1;
    end
  endtask

  task automatic pulseClear(input int n);
    SEGCLR = 1'b0;
    idle(n);
    SEGCLR = 1'b1;
    modelClear();
    idle(4);
  endtask

  task automatic compareEvents(input string tag);
    checkOutput($sformatf("%s_nframes", tag), 64'(got_frames.size()), 64'(exp_frames.size()));
    for (int i = 0; i < got_frames.size() && i < exp_frames.size(); i++)
      checkOutput($sformatf("%s_frame%0d", tag, i), got_frames[i], exp_frames[i]);
    checkOutput($sformatf("%s_nerrs", tag), 64'(got_errs.size()), 64'(exp_errs.size()));
    for (int i = 0; i < got_errs.size() && i < exp_errs.size(); i++)
      checkOutput($sformatf("%s_err%0d", tag, i), 64'(got_errs[i]), 64'(exp_errs[i]));
    got_frames.delete();
    exp_frames.delete();
    got_errs.delete();
    exp_errs.delete();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rv;
    int nb, n0;

    #12;
    checkOutput("rst_frame_data", frame_data, 64'h0);
    checkOutput("rst_valid_err", {frame_valid, frame_err, busy, seg_en}, 4'h0);
    checkOutput("rst_err_code", 64'(err_code), 64'h0);
    checkOutput("rst_bit_cnt", 64'(bit_cnt), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    idle(4);

    applyStimulus(64'hA5C3_0F00_FFEE_1234, 64, 1'b0);
    idle(8);
    checkOutput("t1_frame_data", frame_data, 64'hA5C3_0F00_FFEE_1234);
    checkOutput("t1_bit_cnt", 64'(bit_cnt), 64'h0);
    compareEvents("t1");

    applyStimulus(64'h0123_4567_89AB_CDEF, 64, 1'b0);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 30, 1'b0);
    checkOutput("t2_hold", frame_data, 64'h0123_4567_89AB_CDEF);
    checkOutput("t2_mid_cnt", 64'(bit_cnt), 64'd30);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 34, 1'b0);
    idle(8);
    checkOutput("t2_frame_data", frame_data, 64'hFFFF_FFFF_FFFF_FFFF);
    compareEvents("t2");

    applyStimulus(64'hDEAD_BEEF_0000_0000, 20, 1'b0);
    checkOutput("t3_cnt20", 64'(bit_cnt), 64'd20);
    checkOutput("t3_busy", 64'(busy), 64'h1);
    pulseClear(4);
    checkOutput("t3_err_code", 64'(err_code), 64'h1);
    checkOutput("t3_cleared", 64'(bit_cnt), 64'h0);
    applyStimulus(64'h1111_2222_3333_4444, 64, 1'b0);
    idle(8);
    compareEvents("t3");

    SEGCLR = 1'b0;
    SEGCLK = 1'b1;
    idle(6);
    SEGCLK = 1'b0;
    SEGCLR = 1'b1;
    modelClear();
    idle(6);
    checkOutput("t5_bit_cnt", 64'(bit_cnt), 64'h0);
    checkOutput("t5_busy", 64'(busy), 64'h0);
    compareEvents("t5");

    for (int k = 0; k < 6; k++) begin
      rv = {$urandom, $urandom};
      SEGEN = 1'($urandom_range(0, 1));
      nb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 63) : 64;
      applyStimulus(rv, nb, 1'b1);
      if (nb != 64) pulseClear($urandom_range(3, 6));
      idle(8);
      checkOutput($sformatf("rnd%0d_cnt", k), 64'(bit_cnt), 64'(rx_bits.size()));
      checkOutput($sformatf("rnd%0d_seg_en", k), 64'(seg_en), 64'(SEGEN));
    end
    compareEvents("rnd");

    n0 = got_errs.size();
    applyStimulus(64'h5A5A_0000_0000_0000, 10, 1'b0);
    exp_errs.push_back(2'b10);
    rx_bits.delete();
    for (int i = 0; i < 1200 && got_errs.size() == n0; i++) @(negedge clk);
    checkOutput("t4_delay", 64'(err_cyc - last_cnt_cyc), 64'd1024);
    checkOutput("t4_err_code", 64'(err_code), 64'h2);
    checkOutput("t4_busy", 64'(busy), 64'h0);
    compareEvents("t4");

    SEGEN = 1'b1;
    applyStimulus(64'hCAFE_F00D_1234_5678, 40, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_frame_data", frame_data, 64'h0);
    checkOutput("t6_flags", {frame_valid, frame_err, busy, seg_en}, 4'h0);
    checkOutput("t6_err_code", 64'(err_code), 64'h0);
    checkOutput("t6_bit_cnt", 64'(bit_cnt), 64'h0);
    rx_bits.delete();
    idle(2);
    rst = 1'b1;
    idle(4);
    applyStimulus(64'h8765_4321_0FED_CBA9, 64, 1'b0);
    idle(8);
    checkOutput("t6_frame_after", frame_data, 64'h8765_4321_0FED_CBA9);
    compareEvents("t6");

    checkOutput("valid_err_overlap", 64'(overlap), 64'h0);
    checkOutput("frame_data_stable", 64'(stable_viol), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
